// File: rtl/mac_acc.sv
// -----------------------------------------------------------------------------
// mac_acc -- signed multiply-accumulate stage feeding the aggregation stage.
//
// Accepts LEN signed activation/weight pairs over a valid/ready handshake and
// sums their products in an accumulator that is wide enough never to overflow.
// The finished dot product is reduced to DW bits and held on a valid/ready
// output port until the consumer takes it.
//
// Optional feature macro: MAC_SAT_EN
//   defined   : the result is clamped to the signed DW range, and ovf flags
//               that the clamp was applied.
//   undefined : the result wraps (low DW bits are kept), and ovf is tied to 0.
//
// Parameters
//   DW   output word width (signed)
//   IW   operand width (signed two's complement)
//   LEN  products per result (>= 1)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_x/in_w carry a term
//   in_ready   a term can be accepted this cycle (registered state decode)
//   in_x       signed activation
//   in_w       signed weight
//   sum_valid  sum_out holds a completed result
//   sum_ready  downstream consumes the result this cycle
//   sum_out    signed reduced dot product
//   ovf        result was clamped (qualified by sum_valid)
//   busy       FSM is not idle
// -----------------------------------------------------------------------------
module mac_acc #(
    parameter int DW  = 12,
    parameter int IW  = 6,
    parameter int LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [IW-1:0] in_x,
    input  logic signed [IW-1:0] in_w,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic signed [DW-1:0] sum_out,
    output logic                 ovf,
    output logic                 busy
);

    localparam int AW = 2*IW + $clog2(LEN);
    localparam int CW = $clog2(LEN+1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic signed [AW-1:0]   acc_r, acc_s;
    logic [CW-1:0]          cnt_r, cnt_s;
    logic signed [DW-1:0]   sum_r, sum_s;
    logic                   ovf_r, ovf_s;
    logic                   in_ready_r, sum_valid_r, busy_r;
    logic                   accept_s;
    logic                   load_s;
    logic signed [2*IW-1:0] prod_s;
    logic signed [AW-1:0]   prod_ext_s;
    logic [DW:0]            red_s;

    // Reduce the wide accumulator to the output width; returns {ovf, value}.
    function automatic logic [DW:0] reduce_acc(input logic signed [AW-1:0] v);
`ifdef MAC_SAT_EN
        logic signed [AW-1:0] sat_max;
        logic signed [AW-1:0] sat_min;
        sat_max = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        sat_min = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
        if (v > sat_max) begin
            reduce_acc = {1'b1, sat_max[DW-1:0]};
        end else if (v < sat_min) begin
            reduce_acc = {1'b1, sat_min[DW-1:0]};
        end else begin
            reduce_acc = {1'b0, v[DW-1:0]};
        end
`else
        reduce_acc = {1'b0, v[DW-1:0]};
`endif
    endfunction

    // Signed product, sign-extended to the accumulator width.
    always_comb begin
        prod_s     = (2*IW)'(in_x) * (2*IW)'(in_w);
        prod_ext_s = AW'(prod_s);
    end

    // Next-state, accumulator and result-capture logic.
    always_comb begin
        state_s  = state_r;
        acc_s    = acc_r;
        cnt_s    = cnt_r;
        sum_s    = sum_r;
        ovf_s    = ovf_r;
        load_s   = 1'b0;
        red_s    = {(DW+1){1'b0}};
        accept_s = in_valid && in_ready_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    acc_s = prod_ext_s;
                    cnt_s = CW'(1);
                    if (LEN == 1) begin
                        state_s = ST_HOLD;
                        load_s  = 1'b1;
                    end else begin
                        state_s = ST_ACC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (accept_s) begin
                    acc_s = acc_r + prod_ext_s;
                    cnt_s = cnt_r + CW'(1);
                    if (cnt_r == CW'(LEN-1)) begin
                        state_s = ST_HOLD;
                        load_s  = 1'b1;
                    end else begin
                        state_s = ST_ACC;
                    end
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (sum_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // The result is captured on the same edge as the final accumulation.
        if (load_s) begin
            red_s = reduce_acc(acc_s);
            ovf_s = red_s[DW];
            sum_s = red_s[DW-1:0];
        end else begin
            red_s = {(DW+1){1'b0}};
        end
    end

    // State, datapath and registered output decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            acc_r       <= {AW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            sum_r       <= {DW{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            sum_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            cnt_r       <= cnt_s;
            sum_r       <= sum_s;
            ovf_r       <= ovf_s;
            in_ready_r  <= (state_s != ST_HOLD);
            sum_valid_r <= (state_s == ST_HOLD);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign sum_valid = sum_valid_r;
    assign sum_out   = sum_r;
    assign ovf       = ovf_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mac_acc.sv
// -----------------------------------------------------------------------------
// tb_mac_acc -- directed, scoreboard-based bench for mac_acc (LEN=16 and LEN=1
// instances). Expected results are computed from integer sums of the driven
// terms and queued when the last term of a vector is driven.
// -----------------------------------------------------------------------------
module tb_mac_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid, in_ready;
    logic signed [5:0] in_x, in_w;
    logic              sum_valid, sum_ready;
    logic [11:0]       sum_out;
    logic              ovf, busy;

    logic              v1_in_valid, v1_in_ready;
    logic signed [5:0] v1_in_x, v1_in_w;
    logic              v1_sum_valid, v1_sum_ready;
    logic [11:0]       v1_sum_out;
    logic              v1_ovf, v1_busy;

    int          total_n = 0;
    int          bad_n   = 0;
    int          acc_m   = 0;
    logic [12:0] sb_q[$];
    logic [12:0] exp_v;
    logic [11:0] hold_v;

    mac_acc #(.DW(12), .IW(6), .LEN(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_out(sum_out),
        .ovf(ovf), .busy(busy)
    );

    mac_acc #(.DW(12), .IW(6), .LEN(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(v1_in_valid), .in_ready(v1_in_ready), .in_x(v1_in_x), .in_w(v1_in_w),
        .sum_valid(v1_sum_valid), .sum_ready(v1_sum_ready), .sum_out(v1_sum_out),
        .ovf(v1_ovf), .busy(v1_busy)
    );

    function automatic logic [12:0] model(input int total);
        logic [12:0] r;
`ifdef MAC_SAT_EN
        if (total > 2047) begin
            r = {1'b1, 12'h7FF};
        end else if (total < -2048) begin
            r = {1'b1, 12'h800};
        end else begin
            r = {1'b0, total[11:0]};
        end
`else
        r = {1'b0, total[11:0]};
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_term(input int x, input int w);
        in_x     = 6'(x);
        in_w     = 6'(w);
        in_valid = 1'b1;
        chk("in_ready_at_accept", {31'd0, in_ready}, 32'd1);
        acc_m += x * w;
        step();
        in_valid = 1'b0;
    endtask

    task automatic end_vector();
        sb_q.push_back(model(acc_m));
        acc_m = 0;
    endtask

    task automatic check_result(input string tag);
        for (int i = 0; i < 40 && !sum_valid; i++) step();
        chk({tag, "_valid"}, {31'd0, sum_valid}, 32'd1);
        chk({tag, "_sb_nonempty"}, {31'd0, (sb_q.size() != 0)}, 32'd1);
        if (sb_q.size() != 0) begin
            exp_v = sb_q.pop_front();
            chk({tag, "_sum"}, {20'd0, sum_out}, {20'd0, exp_v[11:0]});
            chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_v[12]});
        end
    endtask

    task automatic consume(input string tag);
        sum_ready = 1'b1;
        step();
        sum_ready = 1'b0;
        chk({tag, "_cons_valid"}, {31'd0, sum_valid}, 32'd0);
        chk({tag, "_cons_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cons_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_sum_valid"}, {31'd0, sum_valid}, 32'd0);
        chk({tag, "_sum_out"}, {20'd0, sum_out}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_v1_valid"}, {31'd0, v1_sum_valid}, 32'd0);
        chk({tag, "_v1_ready"}, {31'd0, v1_in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_x = 6'sd0; in_w = 6'sd0; sum_ready = 1'b0;
        v1_in_valid = 1'b0; v1_in_x = 6'sd0; v1_in_w = 6'sd0; v1_sum_ready = 1'b0;
        step(); step(); step();
        check_reset("reset");
        rst = 1'b0;
        step();

        // Basic sum, back-to-back terms; result visible right after the 16th.
        for (int i = 0; i < 16; i++) begin
            send_term(i, 1);
            if (i == 0) chk("basic_busy", {31'd0, busy}, 32'd1);
            if (i == 14) chk("basic_not_early", {31'd0, sum_valid}, 32'd0);
        end
        end_vector();
        chk("basic_latency", {31'd0, sum_valid}, 32'd1);
        chk("basic_hold_ready", {31'd0, in_ready}, 32'd0);
        check_result("basic");
        consume("basic");

        // Positive overflow.
        for (int i = 0; i < 16; i++) send_term(31, 31);
        end_vector();
        check_result("pos_ovf");
        consume("pos_ovf");

        // Negative overflow.
        for (int i = 0; i < 16; i++) send_term(-32, 31);
        end_vector();
        check_result("neg_ovf");
        consume("neg_ovf");

        // Gaps in in_valid, then a 5-cycle stall with a term offered.
        for (int i = 0; i < 16; i++) begin
            send_term(i, 1);
            if (i != 15) step();
        end
        end_vector();
        hold_v = sum_out;
        check_result("gaps");
        in_x = 6'sd7; in_w = 6'sd7; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_sum", {20'd0, sum_out}, {20'd0, hold_v});
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_valid", {31'd0, sum_valid}, 32'd1);
        end
        in_valid = 1'b0;
        consume("stall");

        // Reset mid-vector; the partial sum must not leak into the next result.
        for (int i = 0; i < 7; i++) send_term(5, 5);
        acc_m = 0;
        #2;
        rst = 1'b1;
        #1;
        check_reset("mid_reset");
        step();
        check_reset("mid_reset_hold");
        rst = 1'b0;
        step();
        for (int i = 0; i < 16; i++) send_term(1, 2);
        end_vector();
        check_result("after_reset");
        consume("after_reset");

        // LEN=1 instance: IDLE goes straight to HOLD.
        v1_in_x = -6'sd3; v1_in_w = 6'sd7; v1_in_valid = 1'b1;
        chk("len1_ready", {31'd0, v1_in_ready}, 32'd1);
        sb_q.push_back(model(-21));
        step();
        v1_in_valid = 1'b0;
        chk("len1_valid", {31'd0, v1_sum_valid}, 32'd1);
        chk("len1_busy", {31'd0, v1_busy}, 32'd1);
        chk("len1_hold_ready", {31'd0, v1_in_ready}, 32'd0);
        exp_v = sb_q.pop_front();
        chk("len1_sum", {20'd0, v1_sum_out}, {20'd0, exp_v[11:0]});
        chk("len1_ovf", {31'd0, v1_ovf}, {31'd0, exp_v[12]});
        v1_sum_ready = 1'b1;
        step();
        v1_sum_ready = 1'b0;
        chk("len1_cons_valid", {31'd0, v1_sum_valid}, 32'd0);
        chk("len1_cons_busy", {31'd0, v1_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule

// File: doc/mac_acc.md
# mac_acc

Multiply-accumulate stage that sits directly upstream of the aggregation stage in the neural-network accelerator datapath. It accepts a stream of signed activation/weight pairs over a valid/ready handshake and accumulates `LEN` products into one dot-product result. It then presents the result, reduced to the aggregation word width, on a held valid/ready output port. That output feeds the aggregation stage's 12-bit input.

## Interface
- `DW`, 12: output word width in bits, signed; matches the aggregation input width.
- `IW`, 6: operand width in bits, signed two's complement.
- `LEN`, 16: number of products per result; must be 1 or greater.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `in_x`/`in_w` carry a term.
- `in_ready`  out  1  block can accept a term this cycle.
- `in_x`  in  IW  signed activation operand.
- `in_w`  in  IW  signed weight operand.
- `sum_valid`  out  1  `sum_out` holds a completed result.
- `sum_ready`  in  1  downstream consumes the result this cycle.
- `sum_out`  out  DW  signed dot-product result.
- `ovf`  out  1  the current result exceeded the DW range; qualified by `sum_valid`.
- `busy`  out  1  state is not IDLE.

## Operation
- Internal accumulator width: AW = 2*IW + clog2(LEN). Internal sums never overflow.
- Product: `in_x * in_w`, signed, 2*IW bits, sign-extended to AW.
- A term is accepted when `in_valid && in_ready`.
- The FSM has three states: IDLE, ACC and HOLD.
- IDLE:
  - `in_ready` = 1.
  - On accept: acc <= product, cnt <= 1.
  - Next state is HOLD if LEN == 1, otherwise ACC.
- ACC:
  - `in_ready` = 1.
  - On accept: acc <= acc + product, cnt <= cnt + 1.
  - On the accept where cnt == LEN-1, go to HOLD.
  - With no accept, state, acc and cnt hold. Gaps in `in_valid` are legal.
- HOLD:
  - `in_ready` = 0.
  - `sum_out`, `ovf` and `sum_valid` = 1 are held stable.
  - When `sum_ready` = 1, the result is consumed: `sum_valid` drops and the next state is IDLE.
- Entry to HOLD registers the reduced result into `sum_out` in the same edge as the final accumulation.
- Reduction from AW bits to DW bits is set by `MAC_SAT_EN`; see Configuration.
- `busy` = (state != IDLE).
- Reset mid-operation discards the partial sum and any pending result. No term accepted before reset contributes to a later result.

## Timing
- Reset values: `in_ready` = 1, `sum_valid` = 0, `sum_out` = 0, `ovf` = 0, `busy` = 0. Internally, state = IDLE, acc = 0, cnt = 0.
- Throughput: one term per cycle while `in_valid` is held high.
- Latency: `sum_valid` rises on the edge that accepts the LEN-th term, so it is visible the cycle after that term is presented.
- Minimum period per result: LEN + 1 cycles with `sum_ready` tied high. This includes one HOLD cycle, during which `in_ready` = 0.
- Backpressure: `sum_valid` stays high and `sum_out`/`ovf` stay unchanged for as long as `sum_ready` = 0. No new term is accepted during this time.
- `sum_ready` is ignored outside HOLD.
- `in_ready` is a registered-state decode; it has no combinational path from `sum_ready`.

## Configuration
- Macro: `MAC_SAT_EN`.
- Defined:
  - acc is clamped to [-2^(DW-1), 2^(DW-1)-1].
  - `ovf` = 1 when clamping occurred for this result, otherwise 0.
- Undefined:
  - `sum_out` = acc[DW-1:0]; the value wraps.
  - `ovf` is tied to 0 and the clamp logic is absent.

## Test plan
- Basic sum (LEN=16): x = 0..15, w = 1, one term per cycle -> `sum_out` = 120 (0x078), `ovf` = 0, `sum_valid` rises the cycle after the 16th term.
- Positive overflow: 16 terms of x = 31, w = 31 (total 15376) -> with `MAC_SAT_EN`, `sum_out` = 0x7FF and `ovf` = 1; without it, `sum_out` = 0xC10 and `ovf` = 0.
- Negative overflow: 16 terms of x = -32, w = 31 (total -15872) -> with `MAC_SAT_EN`, `sum_out` = 0x800 and `ovf` = 1.
- Backpressure and gaps:
  - `in_valid` toggles 1/0 across the vector and `sum_ready` is held 0 for 5 cycles after `sum_valid` -> result is still 120.
  - `sum_out` is stable and `in_ready` = 0 throughout the stall.
  - IDLE is reached one cycle after `sum_ready` = 1.
- Reset mid-vector: assert `rst` after 7 accepted terms of x = 5, w = 5, then send 16 terms of x = 1, w = 2 -> `sum_out` = 32. All outputs take their reset values while `rst` is high.
- LEN = 1 instance: a single term x = -3, w = 7 -> `sum_out` = -21 (0xFEB) on the next cycle, and the FSM goes from IDLE directly to HOLD.
